// File: rtl/alarm_pkg.sv
// Shared encodings and limits for the alarm controller.
// States, BCD wrap limits and the ring/snooze counter width.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETMIN  = 3'd1,
    ST_SETHOUR = 3'd2,
    ST_RING    = 3'd3,
    ST_SNOOZE  = 3'd4
  } state_t;

  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam int         CNT_W    = 12;

endpackage

// File: rtl/alarm_ctrl_bcd2_inc.sv
// Two-digit BCD incrementer (combinational); wraps to 00 once the value reaches MAX.
module bcd2_inc #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val,
  output logic [7:0] nxt
);

  always_comb begin
    nxt = 8'h00;
    if (val == MAX)
      nxt = 8'h00;
    else if (val[3:0] == 4'h9)
      nxt = {val[7:4] + 4'h1, 4'h0};
    else
      nxt = {val[7:4], val[3:0] + 4'h1};
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm time entry, match detection, buzzer ring with auto-stop.
// Optional snooze state is built in when ALARM_SNOOZE_EN is defined.
//
// state      | meaning
// ST_IDLE    | showing clock time; arm toggle; waits for a match
// ST_SETMIN  | editing alarm minutes (minute digits blink)
// ST_SETHOUR | editing alarm hours (hour digits blink)
// ST_RING    | buzzer follows SIG2HZ until timeout or user stop
// ST_SNOOZE  | buzzer silent, counting down to the next ring
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RINGSEC   = 60,
  parameter int SNOOZEMIN = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SIG2HZ,
  input  logic       SECTICK,
  input  logic       ALMSET,
  input  logic       SELECT,
  input  logic       ADJUST,
  input  logic       ALMONOFF,
  input  logic [7:0] CURHOUR,
  input  logic [7:0] CURMIN,
  output logic [7:0] ALMHOUR,
  output logic [7:0] ALMMIN,
  output logic       ALMHOURON,
  output logic       ALMMINON,
  output logic       ALMDISP,
  output logic       ARMED,
  output logic       BUZZER
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RINGSEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZEMIN * 60 - 1);

  state_t             state;
  logic [7:0]         almhour;
  logic [7:0]         almmin;
  logic               armed;
  logic               fired;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_last;
  logic [7:0]         min_nxt;
  logic [7:0]         hour_nxt;
  logic               match;

  bcd2_inc #(.MAX(MIN_MAX))  u_min_inc  (.val(almmin),  .nxt(min_nxt));
  bcd2_inc #(.MAX(HOUR_MAX)) u_hour_inc (.val(almhour), .nxt(hour_nxt));

  assign match    = (CURHOUR == almhour) && (CURMIN == almmin);
  assign cnt_last = (state == ST_SNOOZE) ? SNOOZE_LAST : RING_LAST;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      almhour <= 8'h00;
      almmin  <= 8'h00;
      armed   <= 1'b0;
      fired   <= 1'b0;
      cnt     <= '0;
    end else begin
      // fired tracks the matching minute so each minute can trigger at most once
      fired <= match;
      case (state)
        ST_IDLE: begin
          if (ALMONOFF)
            armed <= ~armed;
          if (ALMSET)
            state <= ST_SETMIN;
          else if (armed && match && !fired) begin
            state <= ST_RING;
            cnt   <= '0;
          end
        end
        ST_SETMIN: begin
          if (ALMSET)
            state <= ST_IDLE;
          else if (SELECT)
            state <= ST_SETHOUR;
          else if (ADJUST)
            almmin <= min_nxt;
        end
        ST_SETHOUR: begin
          if (ALMSET)
            state <= ST_IDLE;
          else if (SELECT)
            state <= ST_SETMIN;
          else if (ADJUST)
            almhour <= hour_nxt;
        end
        ST_RING: begin
          if (ALMONOFF || ADJUST || ALMSET)
            state <= ST_IDLE;
          else if (SELECT) begin
`ifdef ALARM_SNOOZE_EN
            state <= ST_SNOOZE;
            cnt   <= '0;
`else
            state <= ST_IDLE;
`endif
          end else if (SECTICK) begin
            if (cnt == cnt_last)
              state <= ST_IDLE;
            else
              cnt <= cnt + 1'b1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (ALMONOFF || ALMSET)
            state <= ST_IDLE;
          else if (SECTICK) begin
            if (cnt == cnt_last) begin
              state <= ST_RING;
              cnt   <= '0;
            end else
              cnt <= cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ALMHOUR   = almhour;
  assign ALMMIN    = almmin;
  assign ARMED     = armed;
  assign ALMDISP   = (state == ST_SETMIN) || (state == ST_SETHOUR);
  assign ALMMINON  = ~((state == ST_SETMIN) && SIG2HZ);
  assign ALMHOURON = ~((state == ST_SETHOUR) && SIG2HZ);
  assign BUZZER    = (state == ST_RING) && SIG2HZ;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: expectations queued with each stimulus, compared after the clock.
module tb_alarm_ctrl;

  localparam logic [4:0] B_SET = 5'b00001;
  localparam logic [4:0] B_SEL = 5'b00010;
  localparam logic [4:0] B_ADJ = 5'b00100;
  localparam logic [4:0] B_ONF = 5'b01000;
  localparam logic [4:0] B_SEC = 5'b10000;

  localparam int F_HOUR = 0, F_MIN = 1, F_DISP = 2, F_ARMED = 3, F_BUZ = 4, F_HON = 5, F_MON = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SIG2HZ = 1'b1;
  logic       SECTICK = 1'b0;
  logic       ALMSET = 1'b0;
  logic       SELECT = 1'b0;
  logic       ADJUST = 1'b0;
  logic       ALMONOFF = 1'b0;
  logic [7:0] CURHOUR = 8'h12;
  logic [7:0] CURMIN = 8'h00;
  logic [7:0] ALMHOUR;
  logic [7:0] ALMMIN;
  logic       ALMHOURON;
  logic       ALMMINON;
  logic       ALMDISP;
  logic       ARMED;
  logic       BUZZER;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  alarm_ctrl #(.RINGSEC(60), .SNOOZEMIN(1)) dut (
    .CLK(CLK), .RST(RST), .SIG2HZ(SIG2HZ), .SECTICK(SECTICK),
    .ALMSET(ALMSET), .SELECT(SELECT), .ADJUST(ADJUST), .ALMONOFF(ALMONOFF),
    .CURHOUR(CURHOUR), .CURMIN(CURMIN),
    .ALMHOUR(ALMHOUR), .ALMMIN(ALMMIN), .ALMHOURON(ALMHOURON), .ALMMINON(ALMMINON),
    .ALMDISP(ALMDISP), .ARMED(ARMED), .BUZZER(BUZZER)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] field(input int sel);
    case (sel)
      F_HOUR:  return ALMHOUR;
      F_MIN:   return ALMMIN;
      F_DISP:  return {7'd0, ALMDISP};
      F_ARMED: return {7'd0, ARMED};
      F_BUZ:   return {7'd0, BUZZER};
      F_HON:   return {7'd0, ALMHOURON};
      default: return {7'd0, ALMMINON};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [7:0] e);
    sb.push_back('{tag, sel, e});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, field(e.sel), e.exp);
    end
  endtask

  // one-cycle pulse on the buttons in mask, outputs settle before the return
  task automatic press(input logic [4:0] mask);
    @(negedge CLK);
    ALMSET   = mask[0];
    SELECT   = mask[1];
    ADJUST   = mask[2];
    ALMONOFF = mask[3];
    SECTICK  = mask[4];
    @(negedge CLK);
    {ALMSET, SELECT, ADJUST, ALMONOFF, SECTICK} = 5'b0;
  endtask

  task automatic press_n(input logic [4:0] mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m);
    @(negedge CLK);
    CURHOUR = h;
    CURMIN  = m;
    @(negedge CLK);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    // reset
    RST = 1'b0;
    idle_cycles(2);
    expect_out("rst_hour", F_HOUR, 8'h00);
    expect_out("rst_min", F_MIN, 8'h00);
    expect_out("rst_disp", F_DISP, 8'h00);
    expect_out("rst_armed", F_ARMED, 8'h00);
    expect_out("rst_buz", F_BUZ, 8'h00);
    expect_out("rst_hon", F_HON, 8'h01);
    expect_out("rst_mon", F_MON, 8'h01);
    drain();
    RST = 1'b1;
    idle_cycles(1);

    // basic set sequence
    expect_out("set_disp", F_DISP, 8'h01);
    expect_out("setmin_blink", F_MON, 8'h00);
    expect_out("setmin_hon", F_HON, 8'h01);
    press(B_SET);
    drain();
    SIG2HZ = 1'b0;
    #1;
    expect_out("setmin_lowphase", F_MON, 8'h01);
    drain();
    SIG2HZ = 1'b1;
    press_n(B_ADJ, 3);
    expect_out("min_3", F_MIN, 8'h03);
    drain();
    expect_out("sethour_blink", F_HON, 8'h00);
    expect_out("sethour_mon", F_MON, 8'h01);
    press(B_SEL);
    drain();
    press_n(B_ADJ, 2);
    expect_out("hour_2", F_HOUR, 8'h02);
    drain();
    expect_out("exit_disp", F_DISP, 8'h00);
    expect_out("exit_min", F_MIN, 8'h03);
    expect_out("exit_hour", F_HOUR, 8'h02);
    press(B_SET);
    drain();

    // BCD wrap boundaries
    press(B_SET);
    press_n(B_ADJ, 56);
    expect_out("min_59", F_MIN, 8'h59);
    drain();
    expect_out("min_wrap", F_MIN, 8'h00);
    expect_out("min_wrap_nocarry", F_HOUR, 8'h02);
    press(B_ADJ);
    drain();
    press(B_SEL);
    press_n(B_ADJ, 21);
    expect_out("hour_23", F_HOUR, 8'h23);
    drain();
    expect_out("hour_wrap", F_HOUR, 8'h00);
    press(B_ADJ);
    drain();
    press_n(B_ADJ, 9);
    expect_out("hour_09", F_HOUR, 8'h09);
    drain();
    expect_out("hour_10", F_HOUR, 8'h10);
    press(B_ADJ);
    drain();
    expect_out("prio_disp", F_DISP, 8'h00);
    expect_out("prio_hour", F_HOUR, 8'h10);
    press(B_SET | B_SEL | B_ADJ);
    drain();

    // program 07:30
    press(B_SET);
    press_n(B_ADJ, 30);
    press(B_SEL);
    press_n(B_ADJ, 21);
    press(B_SET);
    expect_out("prog_hour", F_HOUR, 8'h07);
    expect_out("prog_min", F_MIN, 8'h30);
    expect_out("idle_ign_min", F_MIN, 8'h30);
    expect_out("idle_ign_disp", F_DISP, 8'h00);
    press(B_SEL | B_ADJ);
    drain();

    // armed ring, timeout, no retrigger
    expect_out("arm_on", F_ARMED, 8'h01);
    press(B_ONF);
    drain();
    set_time(8'h07, 8'h29);
    expect_out("ring_start", F_BUZ, 8'h01);
    set_time(8'h07, 8'h30);
    drain();
    SIG2HZ = 1'b0;
    #1;
    expect_out("ring_lowphase", F_BUZ, 8'h00);
    drain();
    SIG2HZ = 1'b1;
    press_n(B_SEC, 59);
    expect_out("ring_59s", F_BUZ, 8'h01);
    drain();
    expect_out("ring_timeout", F_BUZ, 8'h00);
    press(B_SEC);
    drain();
    idle_cycles(5);
    expect_out("no_retrigger", F_BUZ, 8'h00);
    drain();

    // user stop keeps arm; adjust also stops
    set_time(8'h07, 8'h31);
    set_time(8'h07, 8'h30);
    expect_out("ring2", F_BUZ, 8'h01);
    drain();
    expect_out("onoff_stop", F_BUZ, 8'h00);
    expect_out("onoff_armed", F_ARMED, 8'h01);
    press(B_ONF);
    drain();
    set_time(8'h07, 8'h31);
    set_time(8'h07, 8'h30);
    expect_out("ring3", F_BUZ, 8'h01);
    drain();
    expect_out("adj_stop", F_BUZ, 8'h00);
    expect_out("adj_stop_min", F_MIN, 8'h30);
    press(B_ADJ);
    drain();
    set_time(8'h07, 8'h31);
    expect_out("disarm", F_ARMED, 8'h00);
    press(B_ONF);
    drain();
    set_time(8'h07, 8'h30);
    idle_cycles(2);
    expect_out("disarmed_noring", F_BUZ, 8'h00);
    drain();

    // match during set mode suppresses ring in that minute
    set_time(8'h07, 8'h31);
    press(B_ONF);
    press(B_SET);
    press(B_SEL);
    set_time(8'h07, 8'h30);
    idle_cycles(2);
    press(B_SET);
    idle_cycles(3);
    expect_out("setmatch_noring", F_BUZ, 8'h00);
    expect_out("setmatch_disp", F_DISP, 8'h00);
    expect_out("setmatch_armed", F_ARMED, 8'h01);
    drain();

    // select while ringing
    set_time(8'h07, 8'h31);
    set_time(8'h07, 8'h30);
    expect_out("ring4", F_BUZ, 8'h01);
    drain();
    expect_out("select_silent", F_BUZ, 8'h00);
    press(B_SEL);
    drain();
`ifdef ALARM_SNOOZE_EN
    press_n(B_SEC, 59);
    expect_out("snooze_59s", F_BUZ, 8'h00);
    drain();
    expect_out("snooze_rering", F_BUZ, 8'h01);
    press(B_SEC);
    drain();
    expect_out("snooze_stop", F_BUZ, 8'h00);
    press(B_ONF);
    drain();
`else
    press_n(B_SEC, 3);
    expect_out("select_idle", F_BUZ, 8'h00);
    expect_out("select_armed", F_ARMED, 8'h01);
    drain();
`endif

    // reset while ringing
    set_time(8'h07, 8'h31);
    set_time(8'h07, 8'h30);
    expect_out("ring5", F_BUZ, 8'h01);
    drain();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    expect_out("rst_ring_buz", F_BUZ, 8'h00);
    expect_out("rst_ring_armed", F_ARMED, 8'h00);
    expect_out("rst_ring_min", F_MIN, 8'h00);
    expect_out("rst_ring_hour", F_HOUR, 8'h00);
    drain();
    RST = 1'b1;
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
